// File: rtl/regfile_wb_queue.sv
// ============================================================================
// Module   : regfile_wb_queue
// Brief    : In-order writeback commit queue that feeds the register-file
//            write port. It merges ALU and LSU results, with the LSU taking
//            priority, and retires one write per cycle. It also reports
//            pending writes and forwarding data for two decode sources.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd_addr,
    input  logic [31:0] i_alu_rd_data,
    output logic        o_alu_ready,
    input  logic        i_lsu_valid,
    input  logic [4:0]  i_lsu_rd_addr,
    input  logic [31:0] i_lsu_rd_data,
    output logic        o_lsu_ready,
    output logic        o_rd_wren,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic        o_rs1_pending,
    output logic        o_rs2_pending,
    output logic [31:0] o_rs1_fwd_data,
    output logic [31:0] o_rs2_fwd_data,
    output logic        o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [4:0]       mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             not_empty;
    logic             enq_fire;
    logic [4:0]       enq_addr;
    logic [31:0]      enq_data;
    logic             store;

    // Handshake: readiness depends only on registered occupancy and LSU valid,
    // so a full queue refuses even in a cycle where it is draining.
    always_comb begin
        full        = (count == C_FULL);
        not_empty   = (count != '0);
        o_lsu_ready = !full;
        o_alu_ready = !full && !i_lsu_valid;
        enq_fire    = (i_lsu_valid && o_lsu_ready) || (i_alu_valid && o_alu_ready);
        enq_addr    = i_lsu_valid ? i_lsu_rd_addr : i_alu_rd_addr;
        enq_data    = i_lsu_valid ? i_lsu_rd_data : i_alu_rd_data;
        // Writes to x0 finish their handshake but are never queued.
        store       = enq_fire && (enq_addr != 5'd0);
    end

    // Queue storage and pointers; the head drains every cycle the queue is occupied.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= 5'd0;
                mem_data[i] <= 32'd0;
            end
        end else begin
            if (store) begin
                mem_addr[tail] <= enq_addr;
                mem_data[tail] <= enq_data;
                tail           <= tail + 1'b1;
            end
            if (not_empty) begin
                head <= head + 1'b1;
            end
            case ({store, not_empty})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Write port presents the head entry whenever anything is queued.
    always_comb begin
        o_empty   = !not_empty;
        o_rd_wren = not_empty;
        o_rd_addr = not_empty ? mem_addr[head] : 5'd0;
        o_rd_data = not_empty ? mem_data[head] : 32'd0;
    end

    // Scan from oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx            = '0;
        o_rs1_pending  = 1'b0;
        o_rs2_pending  = 1'b0;
        o_rs1_fwd_data = 32'd0;
        o_rs2_fwd_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((i_rs1_addr != 5'd0) && (mem_addr[idx] == i_rs1_addr)) begin
                    o_rs1_pending  = 1'b1;
                    o_rs1_fwd_data = mem_data[idx];
                end
                if ((i_rs2_addr != 5'd0) && (mem_addr[idx] == i_rs2_addr)) begin
                    o_rs2_pending  = 1'b1;
                    o_rs2_fwd_data = mem_data[idx];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
// ============================================================================
// Module   : tb_regfile_wb_queue
// Brief    : Scoreboard bench for regfile_wb_queue. A queue-level reference
//            model predicts the handshakes and the pending/forward outputs.
//            Expected register-file writes go into a scoreboard that a
//            separate monitor drains on every write-port cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic [4:0]  i_alu_rd_addr = '0;
    logic [31:0] i_alu_rd_data = '0;
    logic        o_alu_ready;
    logic        i_lsu_valid = 1'b0;
    logic [4:0]  i_lsu_rd_addr = '0;
    logic [31:0] i_lsu_rd_data = '0;
    logic        o_lsu_ready;
    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic [4:0]  i_rs1_addr = '0;
    logic [4:0]  i_rs2_addr = '0;
    logic        o_rs1_pending;
    logic        o_rs2_pending;
    logic [31:0] o_rs1_fwd_data;
    logic [31:0] o_rs2_fwd_data;
    logic        o_empty;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t model_q[$];   // contents of the queue as the model sees it
    ent_t exp_q[$];     // writes the register file must still receive

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_alu_valid   (i_alu_valid),
        .i_alu_rd_addr (i_alu_rd_addr),
        .i_alu_rd_data (i_alu_rd_data),
        .o_alu_ready   (o_alu_ready),
        .i_lsu_valid   (i_lsu_valid),
        .i_lsu_rd_addr (i_lsu_rd_addr),
        .i_lsu_rd_data (i_lsu_rd_data),
        .o_lsu_ready   (o_lsu_ready),
        .o_rd_wren     (o_rd_wren),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .o_rs1_pending (o_rs1_pending),
        .o_rs2_pending (o_rs2_pending),
        .o_rs1_fwd_data(o_rs1_fwd_data),
        .o_rs2_fwd_data(o_rs2_fwd_data),
        .o_empty       (o_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // {pending, fwd_data} for a source register, from the model queue contents.
    function automatic logic [32:0] model_fwd(input logic [4:0] r);
        logic [32:0] res;
        res = '0;
        foreach (model_q[i]) begin
            if (r != 5'd0 && model_q[i].a == r) res = {1'b1, model_q[i].d};
        end
        return res;
    endfunction

    // Monitor: every write-port cycle must match the oldest expected write.
    always @(negedge i_clk) begin
        if (!i_rst && o_rd_wren) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {27'd0, o_rd_addr}, 32'd0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, o_rd_addr}, {27'd0, e.a});
                check("wr_data", o_rd_data, e.d);
            end
        end
    end

    // One cycle: drive inputs just after the edge, check outputs against the
    // model, then advance the model to what the next edge will produce.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        logic        full;
        logic        acc;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [32:0] f1;
        logic [32:0] f2;
        i_alu_valid = av; i_alu_rd_addr = aa; i_alu_rd_data = ad;
        i_lsu_valid = lv; i_lsu_rd_addr = la; i_lsu_rd_data = ld;
        i_rs1_addr  = r1; i_rs2_addr    = r2;
        #1;
        full = (model_q.size() == DEPTH);
        f1   = model_fwd(r1);
        f2   = model_fwd(r2);
        check("lsu_ready", {31'd0, o_lsu_ready}, {31'd0, !full});
        check("alu_ready", {31'd0, o_alu_ready}, {31'd0, !full && !lv});
        check("empty",     {31'd0, o_empty},     {31'd0, model_q.size() == 0});
        check("rd_wren",   {31'd0, o_rd_wren},   {31'd0, model_q.size() != 0});
        check("rd_addr_port", {27'd0, o_rd_addr},
              (model_q.size() != 0) ? {27'd0, model_q[0].a} : 32'd0);
        check("rd_data_port", o_rd_data, (model_q.size() != 0) ? model_q[0].d : 32'd0);
        check("rs1_pending", {31'd0, o_rs1_pending}, {31'd0, f1[32]});
        check("rs1_fwd",     o_rs1_fwd_data, f1[31:0]);
        check("rs2_pending", {31'd0, o_rs2_pending}, {31'd0, f2[32]});
        check("rs2_fwd",     o_rs2_fwd_data, f2[31:0]);
        acc = !full && (lv || av);
        ea  = lv ? la : aa;
        ed  = lv ? ld : ad;
        if (model_q.size() != 0) void'(model_q.pop_front());
        if (acc && ea != 5'd0) begin
            model_q.push_back('{ea, ed});
            exp_q.push_back('{ea, ed});
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values, including ALU ready tracking LSU valid during reset.
        #12;
        check("rst_wren",  {31'd0, o_rd_wren}, 32'd0);
        check("rst_empty", {31'd0, o_empty}, 32'd1);
        check("rst_lsu_ready", {31'd0, o_lsu_ready}, 32'd1);
        check("rst_alu_ready", {31'd0, o_alu_ready}, 32'd1);
        i_lsu_valid = 1'b1;
        #1;
        check("rst_alu_ready_lsu", {31'd0, o_alu_ready}, 32'd0);
        i_lsu_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // ALU write to x5, then verify the write port and drain explicitly.
        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        check("x5_wren", {31'd0, o_rd_wren}, 32'd1);
        check("x5_addr", {27'd0, o_rd_addr}, 32'd5);
        check("x5_data", o_rd_data, 32'h1234_5678);
        idle(1);
        check("x5_drained_empty", {31'd0, o_empty}, 32'd1);

        // Simultaneous ALU/LSU: LSU wins, ALU held until accepted.
        step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd3, 5'd4);
        step(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        idle(2);

        // Back-to-back LSU stream across several pointer laps.
        for (int k = 0; k < 4 * DEPTH; k++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(1 + (k % 31)), 32'hC000_0000 + k, 5'(1 + (k % 31)), 5'd9);
        idle(2);

        // Same register twice: youngest value forwarded.
        step(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        step(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        check("x7_fwd_young", o_rs1_fwd_data, 32'h22);
        idle(2);

        // x0 write is acknowledged but never stored.
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("x0_empty", {31'd0, o_empty}, 32'd1);
        check("x0_wren",  {31'd0, o_rd_wren}, 32'd0);

        // Randomised traffic with a small register range to force matches.
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        // Asynchronous reset mid-cycle with traffic in flight.
        for (int k = 0; k < 3; k++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + k), 32'hD00 + k, 5'd10, 5'd11);
        i_lsu_valid = 1'b0;
        i_rs1_addr  = 5'd12;
        #2;
        i_rst = 1'b1;
        exp_q.delete();
        model_q.delete();
        #1;
        check("arst_wren",  {31'd0, o_rd_wren}, 32'd0);
        check("arst_addr",  {27'd0, o_rd_addr}, 32'd0);
        check("arst_data",  o_rd_data, 32'd0);
        check("arst_empty", {31'd0, o_empty}, 32'd1);
        check("arst_pend",  {31'd0, o_rs1_pending}, 32'd0);
        check("arst_fwd",   o_rs1_fwd_data, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        idle(4);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
